// File: rtl/spi_cfg_arbiter.sv
// rtl/spi_cfg_arbiter.sv - round-robin owner arbitration of the shared spi_master among cfg sequencers
module spi_cfg_arbiter #(
  parameter int N_CLI      = 3,
  parameter int MOSI_W     = 24,
  parameter int MISO_W     = 9,
  parameter int GAP_CYCLES = 8
) (
  input  logic                    clk_20m,
  input  logic                    rstn,
  input  logic [N_CLI-1:0]        cli_req,
  output logic [N_CLI-1:0]        cli_gnt,
  input  logic [N_CLI-1:0]        cli_wr_cmd,
  input  logic [N_CLI-1:0]        cli_rd_cmd,
  input  logic [N_CLI*MOSI_W-1:0] cli_wr_data,
  output logic [MISO_W-1:0]       cli_rd_data,
  output logic [N_CLI-1:0]        cli_busy,
  output logic                    spi_wr_cmd,
  output logic                    spi_rd_cmd,
  output logic [MOSI_W-1:0]       spi_wr_data,
  input  logic [MISO_W-1:0]       spi_rd_data,
  input  logic                    spi_busy,
  input  logic                    spi_cs_n,
  output logic [N_CLI-1:0]        dev_cs_n,
  output logic                    err_o
);

  localparam int IW = (N_CLI > 1) ? $clog2(N_CLI) : 1;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, GAP} state_t;

  state_t        state;
  logic [IW-1:0] last_ptr;
  logic [7:0]    gap_cnt;

  // Returns {found, index}; the lowest offset above the last owner wins.
  function automatic logic [IW:0] rr_pick(input logic [N_CLI-1:0] req, input logic [IW-1:0] last);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int i = N_CLI; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= N_CLI) idx = idx - N_CLI;
      if (req[idx]) r = {1'b1, idx[IW-1:0]};
    end
    return r;
  endfunction

  logic              own_act;
  logic [N_CLI-1:0]  own_mask;
  logic              cmd_pend;
  logic              busy_own;
  logic              own_wr;
  logic              own_rd;
  logic              stray;
  logic              accept;
  logic              err_set;
  logic              owner_req;
  logic [IW:0]       pick;
  logic [MOSI_W-1:0] own_word;

  assign own_act   = (state == OWN);
  assign own_mask  = own_act ? cli_gnt : '0;
  assign cmd_pend  = spi_wr_cmd | spi_rd_cmd;
  // spi_master raises busy one cycle after the command, so the registered strobe covers that gap.
  assign busy_own  = spi_busy | cmd_pend;
  assign own_wr    = |(cli_wr_cmd & own_mask);
  assign own_rd    = |(cli_rd_cmd & own_mask);
  assign stray     = |((cli_wr_cmd | cli_rd_cmd) & ~own_mask);
  assign accept    = (own_wr | own_rd) & ~busy_own;
  assign err_set   = stray | ((own_wr | own_rd) & busy_own) | (own_wr & own_rd);
  assign owner_req = |(cli_req & cli_gnt);
  assign pick      = rr_pick(cli_req, last_ptr);

  always_comb begin
    own_word = '0;
    for (int k = 0; k < N_CLI; k++) begin
      if (cli_gnt[k]) own_word = cli_wr_data[k*MOSI_W +: MOSI_W];
    end
  end

  assign cli_busy    = own_act ? (~cli_gnt | {N_CLI{busy_own}}) : '1;
  // cli_gnt is non-zero only in OWN and DRAIN, so it doubles as the chip-select route.
  assign dev_cs_n    = ~(cli_gnt & {N_CLI{~spi_cs_n}});
  assign cli_rd_data = spi_rd_data;

  always_ff @(posedge clk_20m) begin
    if (!rstn) begin
      state       <= IDLE;
      last_ptr    <= IW'(N_CLI - 1);
      gap_cnt     <= '0;
      cli_gnt     <= '0;
      spi_wr_cmd  <= 1'b0;
      spi_rd_cmd  <= 1'b0;
      spi_wr_data <= '0;
      err_o       <= 1'b0;
    end else begin
      spi_wr_cmd <= accept & own_wr;
      spi_rd_cmd <= accept & ~own_wr;
      if (accept) spi_wr_data <= own_word;
      if (err_set) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (pick[IW]) begin
            state    <= OWN;
            last_ptr <= pick[IW-1:0];
            cli_gnt  <= {{(N_CLI-1){1'b0}}, 1'b1} << pick[IW-1:0];
          end
        end
        OWN: begin
          if (!owner_req) begin
            if (busy_own | accept) begin
              state <= DRAIN;
            end else begin
              state   <= GAP;
              cli_gnt <= '0;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        DRAIN: begin
          if (!busy_own) begin
            state   <= GAP;
            cli_gnt <= '0;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_cfg_arbiter.md
Name: spi_cfg_arbiter

Overview:
- Shares the single spi_master (24-bit MOSI, 9-bit MISO result, 3-wire SDIO) among N configuration clients: ad9517_cfg, adc0_cfg, adc1_cfg.
- Replaces the combinational cfg_go mux in top. Adds request/grant arbitration, per-device chip-select routing, command registering, drain-before-switch and an inter-device CS gap.
- Sits directly upstream of spi_master and downstream of the *_cfg sequencers.

Parameters:
- N_CLI, 3, number of clients; index 0 = AD9517, 1 = ADC0, 2 = ADC1.
- MOSI_W, 24, SPI write word width.
- MISO_W, 9, SPI read result width (spi_master miso_data width).
- GAP_CYCLES, 8, clk_20m cycles of idle between releasing one owner and granting the next; range 1..255.

Ports:
- clk_20m  in  1  system clock, 20 MHz.
- rstn  in  1  synchronous, active-low reset.
- cli_req  in  N_CLI  per-client ownership request; level, held for the client's whole cfg sequence.
- cli_gnt  out  N_CLI  one-hot grant; all zero when no owner.
- cli_wr_cmd  in  N_CLI  per-client write strobe, 1 cycle.
- cli_rd_cmd  in  N_CLI  per-client read strobe, 1 cycle.
- cli_wr_data  in  N_CLI*MOSI_W  packed client words; client k occupies [k*MOSI_W +: MOSI_W].
- cli_rd_data  out  MISO_W  spi_rd_data broadcast to all clients.
- cli_busy  out  N_CLI  per-client busy.
- spi_wr_cmd  out  1  to spi_master.
- spi_rd_cmd  out  1  to spi_master.
- spi_wr_data  out  MOSI_W  to spi_master mosi_data.
- spi_rd_data  in  MISO_W  from spi_master miso_data.
- spi_busy  in  1  from spi_master.
- spi_cs_n  in  1  from spi_master ncs_pin.
- dev_cs_n  out  N_CLI  per-device chip selects to pins.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rstn=0 at a clk_20m edge):
  - state=IDLE; cli_gnt=0; cli_busy=all 1; spi_wr_cmd=0; spi_rd_cmd=0; spi_wr_data=0; dev_cs_n=all 1; err_o=0; last owner pointer=N_CLI-1.
- IDLE:
  - If any cli_req is set, grant round-robin, searching upward from last owner+1 with wrap-around.
  - Register owner, set cli_gnt one-hot next cycle, go to OWN.
  - With no request, remain in IDLE.
- OWN:
  - Owner's wr/rd strobe is registered to spi_wr_cmd/spi_rd_cmd; its word is registered to spi_wr_data. Latency is exactly 1 cycle.
  - spi_wr_data holds its value until the next accepted command.
  - cli_busy[owner] = spi_busy OR (command registered this cycle). This closes the 1-cycle window before spi_master raises busy.
  - cli_busy of all non-owners = 1.
- Command validation, in any state:
  - A strobe from a non-owner is dropped and sets err_o.
  - An owner strobe while cli_busy[owner]=1 is dropped and sets err_o.
  - wr and rd strobes together from the owner: wr takes precedence, rd is dropped, err_o is set.
- Release:
  - When cli_req[owner] falls: go to GAP if spi_busy=0 and no command is pending; otherwise go to DRAIN.
  - DRAIN waits until spi_busy=0, then goes to GAP. Strobes arriving in DRAIN are dropped and set err_o.
- GAP:
  - cli_gnt=0, all dev_cs_n=1. Count GAP_CYCLES cycles, then IDLE.
  - The next grant therefore appears no earlier than GAP_CYCLES+2 cycles after release.
  - A request from the same client in GAP is honoured only via the round-robin order.
- Chip select:
  - dev_cs_n[owner] = spi_cs_n in OWN and DRAIN; all other bits = 1.
  - dev_cs_n is combinational from the registered owner, so pins follow spi_master with no added delay.
- err_o clears only on reset.
- Reset mid-transfer: all outputs return to reset values on the next edge. spi_master shares rstn and aborts in the same cycle.

Test Plan:
- Single client: req[0]=1, wr_cmd[0] pulse with data 0x000130 → cli_gnt=001 two cycles later; spi_wr_cmd pulse 1 cycle after the strobe with spi_wr_data=0x000130; dev_cs_n=110 while spi_cs_n=0; cli_busy[0]=1 from the strobe+1 cycle until spi_busy falls.
- Round robin: req=111 held, each client releases after one write → grant order 0,1,2 (001, 010, 100), separated by ≥GAP_CYCLES+2 cycles; then req[0] alone → grant 001.
- Drain: release req[1] while spi_busy=1 → cli_gnt stays 010 and dev_cs_n[1] tracks spi_cs_n until busy drops; then 8 cycles of gnt=000 with all dev_cs_n=111.
- Errors: wr_cmd[2] while owner=0 → no spi_wr_cmd, err_o=1 sticky. Back-to-back owner strobes on consecutive cycles → second dropped, err_o=1.
- Read: owner 1 issues rd_cmd, spi_master returns 0x0A5 → cli_rd_data=0x0A5 after spi_busy falls; spi_rd_cmd is a 1-cycle pulse.
- Reset mid-transfer: rstn=0 during OWN with spi_busy=1 → next edge gnt=000, dev_cs_n=111, spi cmds 0, err_o=0, cli_busy=111.
